axi_line_xfer: RTL and testbench

AXI_LINE_XFER -- requirements
Module: axi_line_xfer

---
 rtl/axi_line_xfer.sv | 190 +++++++++++++++++++
 tb/tb_axi_line_xfer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_line_xfer.sv
`default_nettype none
// ============================================================================
//  Module      : axi_line_xfer
//  Description : Moves one cache line at a time between a client and an
//                AXI-style shim. A refill issues one read burst and gathers
//                the beats into a line buffer. A write-back issues one write
//                burst with the captured line and waits for the write
//                response. Only one transaction is in flight at a time.
//  Ports       : clk_i, rst_i            - clock, synchronous active-high reset
//                req_*                   - client request (addr, we, line, be)
//                rsp_*                   - client response (line, err)
//                rd_req_o/rd_gnt_i, rd_* - shim read command and read beats
//                wr_req_o/wr_gnt_i, wr_* - shim write command and B response
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_line_xfer #(
    parameter int NumWords  = 4,
    parameter int DataWidth = 64,
    parameter int AddrWidth = 64,
    parameter int IdWidth   = 4,
    parameter int TxId      = 0
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    // client request
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic                              req_we_i,
    input  logic [AddrWidth-1:0]              req_addr_i,
    input  logic [NumWords*DataWidth-1:0]     req_wdata_i,
    input  logic [NumWords*DataWidth/8-1:0]   req_be_i,
    // client response
    output logic                              rsp_valid_o,
    input  logic                              rsp_ready_i,
    output logic [NumWords*DataWidth-1:0]     rsp_rdata_o,
    output logic                              rsp_err_o,
    // shim read command
    output logic                              rd_req_o,
    input  logic                              rd_gnt_i,
    output logic [AddrWidth-1:0]              rd_addr_o,
    output logic [$clog2(NumWords)-1:0]       rd_blen_o,
    output logic [2:0]                        rd_size_o,
    output logic [IdWidth-1:0]                rd_id_o,
    // shim read beats
    output logic                              rd_rdy_o,
    input  logic                              rd_valid_i,
    input  logic                              rd_last_i,
    input  logic [DataWidth-1:0]              rd_data_i,
    // shim write command
    output logic                              wr_req_o,
    input  logic                              wr_gnt_i,
    output logic [AddrWidth-1:0]              wr_addr_o,
    output logic [NumWords*DataWidth-1:0]     wr_data_o,
    output logic [NumWords*DataWidth/8-1:0]   wr_be_o,
    output logic [$clog2(NumWords)-1:0]       wr_blen_o,
    output logic [2:0]                        wr_size_o,
    output logic [IdWidth-1:0]                wr_id_o,
    // shim write response
    output logic                              wr_rdy_o,
    input  logic                              wr_valid_i
);

    localparam int c_LINE_BITS = NumWords * DataWidth;
    localparam int c_BE_BITS   = c_LINE_BITS / 8;
    localparam int c_OFF_BITS  = $clog2(c_LINE_BITS / 8);
    localparam int c_CNT_W     = $clog2(NumWords);
    localparam int c_SIZE      = $clog2(DataWidth / 8);

    // One extra counter bit distinguishes "all words filled" from
    // "about to fill the last word", so overrun beats are recognisable.
    localparam logic [c_CNT_W:0] c_LAST_IDX = (c_CNT_W + 1)'(NumWords - 1);
    localparam logic [c_CNT_W:0] c_ONE      = (c_CNT_W + 1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

    state_t                          r_state;
    logic [AddrWidth-1:c_OFF_BITS]   r_addr_hi;
    logic [c_LINE_BITS-1:0]          r_wdata;
    logic [c_BE_BITS-1:0]            r_be;
    logic [c_CNT_W:0]                r_cnt;
    logic                            r_err;
    logic [DataWidth-1:0]            r_words [NumWords];

    logic [AddrWidth-1:0]            w_line_addr;
    logic [c_LINE_BITS-1:0]          w_line;
    logic                            w_unused_addr;

    // Offset bits inside the line are never issued to the shim.
    assign w_unused_addr = ^req_addr_i[c_OFF_BITS-1:0];
    assign w_line_addr   = {r_addr_hi, {c_OFF_BITS{1'b0}}};

    // Word 0 sits at the lowest address, i.e. the least significant slice.
    for (genvar g = 0; g < NumWords; g++) begin : g_pack
        assign w_line[g*DataWidth +: DataWidth] = r_words[g];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_addr_hi <= req_addr_i[AddrWidth-1:c_OFF_BITS];
                        r_wdata   <= req_wdata_i;
                        r_be      <= req_be_i;
                        r_state   <= req_we_i ? ST_WR_REQ : ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    if (rd_gnt_i) begin
                        r_cnt   <= '0;
                        r_state <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rd_valid_i) begin
                        if (!r_cnt[c_CNT_W]) begin
                            r_words[r_cnt[c_CNT_W-1:0]] <= rd_data_i;
                            r_cnt <= r_cnt + c_ONE;
                        end else begin
                            // Beat beyond the line: drop it, flag the error.
                            r_err <= 1'b1;
                        end
                        if (rd_last_i) begin
                            if (r_cnt != c_LAST_IDX) begin
                                r_err <= 1'b1;
                            end
                            r_state <= ST_RSP;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (wr_gnt_i) begin
                        r_state <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (wr_valid_i) begin
                        r_state <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready_i) begin
                        r_err   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode the registered state; they are also masked
    // by reset so nothing is offered while reset is held.
    assign req_ready_o = ~rst_i & (r_state == ST_IDLE);
    assign rd_req_o    = ~rst_i & (r_state == ST_RD_REQ);
    assign rd_rdy_o    = ~rst_i & (r_state == ST_RD_DATA);
    assign wr_req_o    = ~rst_i & (r_state == ST_WR_REQ);
    assign wr_rdy_o    = ~rst_i & (r_state == ST_WR_RESP);
    assign rsp_valid_o = ~rst_i & (r_state == ST_RSP);

    assign rsp_rdata_o = w_line;
    assign rsp_err_o   = r_err;

    assign rd_addr_o   = w_line_addr;
    assign rd_blen_o   = c_CNT_W'(NumWords - 1);
    assign rd_size_o   = 3'(c_SIZE);
    assign rd_id_o     = IdWidth'(TxId);

    assign wr_addr_o   = w_line_addr;
    assign wr_data_o   = r_wdata;
    assign wr_be_o     = r_be;
    assign wr_blen_o   = c_CNT_W'(NumWords - 1);
    assign wr_size_o   = 3'(c_SIZE);
    assign wr_id_o     = IdWidth'(TxId);

endmodule
`default_nettype wire

// File: tb/tb_axi_line_xfer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_line_xfer
//  Description : Directed self-checking bench for axi_line_xfer with the
//                default parameters (4 x 64-bit words per line).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_line_xfer;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           req_valid_i;
    logic           req_ready_o;
    logic           req_we_i;
    logic [63:0]    req_addr_i;
    logic [255:0]   req_wdata_i;
    logic [31:0]    req_be_i;
    logic           rsp_valid_o;
    logic           rsp_ready_i;
    logic [255:0]   rsp_rdata_o;
    logic           rsp_err_o;
    logic           rd_req_o;
    logic           rd_gnt_i;
    logic [63:0]    rd_addr_o;
    logic [1:0]     rd_blen_o;
    logic [2:0]     rd_size_o;
    logic [3:0]     rd_id_o;
    logic           rd_rdy_o;
    logic           rd_valid_i;
    logic           rd_last_i;
    logic [63:0]    rd_data_i;
    logic           wr_req_o;
    logic           wr_gnt_i;
    logic [63:0]    wr_addr_o;
    logic [255:0]   wr_data_o;
    logic [31:0]    wr_be_o;
    logic [1:0]     wr_blen_o;
    logic [2:0]     wr_size_o;
    logic [3:0]     wr_id_o;
    logic           wr_rdy_o;
    logic           wr_valid_i;

    int total = 0;
    int bad   = 0;

    axi_line_xfer dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_be_i    (req_be_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .rd_req_o    (rd_req_o),
        .rd_gnt_i    (rd_gnt_i),
        .rd_addr_o   (rd_addr_o),
        .rd_blen_o   (rd_blen_o),
        .rd_size_o   (rd_size_o),
        .rd_id_o     (rd_id_o),
        .rd_rdy_o    (rd_rdy_o),
        .rd_valid_i  (rd_valid_i),
        .rd_last_i   (rd_last_i),
        .rd_data_i   (rd_data_i),
        .wr_req_o    (wr_req_o),
        .wr_gnt_i    (wr_gnt_i),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .wr_be_o     (wr_be_o),
        .wr_blen_o   (wr_blen_o),
        .wr_size_o   (wr_size_o),
        .wr_id_o     (wr_id_o),
        .wr_rdy_o    (wr_rdy_o),
        .wr_valid_i  (wr_valid_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns 1 when every handshake output is low.
    function automatic logic all_quiet();
        return !(req_ready_o | rd_req_o | wr_req_o | rd_rdy_o | wr_rdy_o | rsp_valid_o);
    endfunction

    localparam logic [255:0] c_W1 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                     64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};

    initial begin
        rst_i = 1'b1; req_valid_i = 0; req_we_i = 0; req_addr_i = '0;
        req_wdata_i = '0; req_be_i = '0; rsp_ready_i = 0; rd_gnt_i = 0;
        rd_valid_i = 0; rd_last_i = 0; rd_data_i = '0; wr_gnt_i = 0; wr_valid_i = 0;

        // ---------------- reset ----------------
        tick();
        tick();
        chk("rst_quiet", 256'(all_quiet()), 256'd1);
        chk("rst_req_ready", 256'(req_ready_o), 256'd0);
        rst_i = 1'b0;
        #1;
        chk("idle_req_ready", 256'(req_ready_o), 256'd1);
        chk("idle_err", 256'(rsp_err_o), 256'd0);
        rd_valid_i = 1'b1;
        #1;
        chk("idle_stray_rd_rdy", 256'(rd_rdy_o), 256'd0);
        rd_valid_i = 1'b0;

        // ---------------- refill, 4 beats ----------------
        req_valid_i = 1; req_we_i = 0; req_addr_i = 64'h8000_0010;
        tick();
        req_valid_i = 0; req_addr_i = '0;
        chk("rf_rd_req", 256'(rd_req_o), 256'd1);
        chk("rf_rd_addr", 256'(rd_addr_o), 256'h8000_0000);
        chk("rf_rd_blen", 256'(rd_blen_o), 256'd3);
        chk("rf_rd_size", 256'(rd_size_o), 256'd3);
        chk("rf_rd_id", 256'(rd_id_o), 256'd0);
        chk("rf_busy_ready", 256'(req_ready_o), 256'd0);
        chk("rf_rdy_before_gnt", 256'(rd_rdy_o), 256'd0);
        rd_gnt_i = 1;
        tick();
        rd_gnt_i = 0;
        chk("rf_rd_rdy", 256'(rd_rdy_o), 256'd1);
        chk("rf_req_dropped", 256'(rd_req_o), 256'd0);
        for (int i = 0; i < 4; i++) begin
            chk("rf_no_rsp_yet", 256'(rsp_valid_o), 256'd0);
            rd_valid_i = 1; rd_data_i = 64'hA + 64'(i); rd_last_i = (i == 3);
            tick();
        end
        rd_valid_i = 0; rd_last_i = 0;
        // Accept cycle + grant cycle + 4 beats: response in cycle 2+NumWords.
        chk("rf_rsp_valid", 256'(rsp_valid_o), 256'd1);
        chk("rf_rdata", rsp_rdata_o, {64'hD, 64'hC, 64'hB, 64'hA});
        chk("rf_err", 256'(rsp_err_o), 256'd0);
        chk("rf_rsp_rd_rdy", 256'(rd_rdy_o), 256'd0);
        rsp_ready_i = 1;
        tick();
        rsp_ready_i = 0;
        chk("rf_back_idle", 256'(req_ready_o), 256'd1);
        chk("rf_rsp_dropped", 256'(rsp_valid_o), 256'd0);

        // ---------------- write-back, grant delayed 3 cycles ----------------
        req_valid_i = 1; req_we_i = 1; req_addr_i = 64'h1234_5678;
        req_wdata_i = c_W1; req_be_i = 32'hFFFF_FFFF;
        tick();
        req_valid_i = 0; req_we_i = 0; req_wdata_i = '1; req_be_i = '0;
        for (int i = 0; i < 4; i++) begin
            chk("wb_wr_req", 256'(wr_req_o), 256'd1);
            chk("wb_wr_data", wr_data_o, c_W1);
            if (i == 0) begin
                chk("wb_wr_addr", 256'(wr_addr_o), 256'h1234_5660);
                chk("wb_wr_be", 256'(wr_be_o), 256'hFFFF_FFFF);
                chk("wb_wr_blen", 256'(wr_blen_o), 256'd3);
                chk("wb_wr_size", 256'(wr_size_o), 256'd3);
                chk("wb_wr_id", 256'(wr_id_o), 256'd0);
                chk("wb_no_rd_req", 256'(rd_req_o), 256'd0);
            end
            wr_gnt_i = (i == 3);
            tick();
        end
        wr_gnt_i = 0;
        chk("wb_req_dropped", 256'(wr_req_o), 256'd0);
        chk("wb_wr_rdy", 256'(wr_rdy_o), 256'd1);
        chk("wb_no_rsp_before_b", 256'(rsp_valid_o), 256'd0);
        tick();
        chk("wb_still_waiting_b", 256'(wr_rdy_o), 256'd1);
        wr_valid_i = 1;
        tick();
        wr_valid_i = 0;
        chk("wb_rsp_valid", 256'(rsp_valid_o), 256'd1);
        chk("wb_wr_rdy_off", 256'(wr_rdy_o), 256'd0);
        chk("wb_err", 256'(rsp_err_o), 256'd0);
        rsp_ready_i = 1;
        tick();
        rsp_ready_i = 0;
        chk("wb_back_idle", 256'(req_ready_o), 256'd1);

        // ---------------- early last + response back-pressure ----------------
        req_valid_i = 1; req_addr_i = 64'h40;
        tick();
        req_valid_i = 0;
        rd_gnt_i = 1;
        tick();
        rd_gnt_i = 0;
        rd_valid_i = 1; rd_data_i = 64'h11; rd_last_i = 0;
        tick();
        rd_data_i = 64'h22; rd_last_i = 1;
        tick();
        rd_valid_i = 0; rd_last_i = 0;
        // Words 2 and 3 keep the previous refill's contents.
        for (int i = 0; i < 5; i++) begin
            chk("el_rsp_valid", 256'(rsp_valid_o), 256'd1);
            chk("el_err", 256'(rsp_err_o), 256'd1);
            chk("el_rdata", rsp_rdata_o, {64'hD, 64'hC, 64'h22, 64'h11});
            chk("el_req_ready", 256'(req_ready_o), 256'd0);
            tick();
        end
        rsp_ready_i = 1;
        tick();
        rsp_ready_i = 0;
        chk("el_err_cleared", 256'(rsp_err_o), 256'd0);
        chk("el_back_idle", 256'(req_ready_o), 256'd1);

        // ---------------- overrun: 5 beats, last on 5th ----------------
        req_valid_i = 1; req_addr_i = 64'h80;
        tick();
        req_valid_i = 0;
        rd_gnt_i = 1;
        tick();
        rd_gnt_i = 0;
        for (int i = 0; i < 5; i++) begin
            rd_valid_i = 1; rd_data_i = 64'h31 + 64'(i); rd_last_i = (i == 4);
            tick();
            if (i == 3) chk("ov_still_reading", 256'(rd_rdy_o), 256'd1);
        end
        rd_valid_i = 0; rd_last_i = 0;
        chk("ov_rsp_valid", 256'(rsp_valid_o), 256'd1);
        chk("ov_err", 256'(rsp_err_o), 256'd1);
        chk("ov_rdata", rsp_rdata_o, {64'h34, 64'h33, 64'h32, 64'h31});
        rsp_ready_i = 1;
        tick();
        rsp_ready_i = 0;

        // ---------------- reset during RD_DATA ----------------
        req_valid_i = 1; req_addr_i = 64'hC0;
        tick();
        req_valid_i = 0;
        rd_gnt_i = 1;
        tick();
        rd_gnt_i = 0;
        rd_valid_i = 1; rd_data_i = 64'h51;
        tick();
        rd_data_i = 64'h52;
        tick();
        rd_valid_i = 0;
        rst_i = 1;
        #1;
        chk("mr_in_reset_quiet", 256'(all_quiet()), 256'd1);
        tick();
        rst_i = 0;
        #1;
        chk("mr_idle_ready", 256'(req_ready_o), 256'd1);
        chk("mr_no_rd_rdy", 256'(rd_rdy_o), 256'd0);
        chk("mr_no_rsp", 256'(rsp_valid_o), 256'd0);
        chk("mr_err_zero", 256'(rsp_err_o), 256'd0);
        req_valid_i = 1; req_addr_i = 64'h100;
        tick();
        req_valid_i = 0;
        rd_gnt_i = 1;
        tick();
        rd_gnt_i = 0;
        for (int i = 0; i < 4; i++) begin
            rd_valid_i = 1; rd_data_i = 64'h61 + 64'(i); rd_last_i = (i == 3);
            tick();
        end
        rd_valid_i = 0; rd_last_i = 0;
        chk("mr_rsp_valid", 256'(rsp_valid_o), 256'd1);
        chk("mr_rdata", rsp_rdata_o, {64'h64, 64'h63, 64'h62, 64'h61});
        chk("mr_err", 256'(rsp_err_o), 256'd0);
        rsp_ready_i = 1;
        tick();
        rsp_ready_i = 0;
        chk("mr_back_idle", 256'(req_ready_o), 256'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
